// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the unified-memory fetch/load-store arbiter.
// State and grant encodings are reused by the hazard unit and the benches.
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

    function automatic int starve_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module imem_dmem_arbiter_sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MaxV = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MaxV)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch and load/store onto one single-ported memory.
// One req/ack transaction at a time, followed by a one-cycle response.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    input  logic              IFlush,
    output logic              InstrRdy,
    output logic [DATA_W-1:0] InstrFill,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DataRdy,
    output logic [DATA_W-1:0] DRData,
    output logic              FetchStall,
    output logic              MemStall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int CW = starve_w(STARVE_MAX);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    arb_gnt_e          gnt_q, gnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              drop_q, drop_d;
    logic              st_inc, st_clr;
    logic [CW-1:0]     starve;
    logic              starve_max;

    assign starve_max = (starve == StarveMax);

    imem_dmem_arbiter_sat_counter #(
        .W   (CW),
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (st_inc),
        .clr_i (st_clr),
        .cnt_o (starve)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_q      <= '0;
            drdata_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_q      <= fill_d;
            drdata_q    <= drdata_d;
            drop_q      <= drop_d;
        end
    end

    // Key: state, DReq, IReq, starvation hit, MemAck
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_d      = fill_q;
        drdata_d    = drdata_q;
        drop_d      = drop_q;
        st_inc      = 1'b0;
        st_clr      = (state_q == ST_IDLE) && !IReq;
        unique casez ({state_q, DReq, IReq, starve_max, MemAck})
            {ST_IDLE, 4'b10??},
            {ST_IDLE, 4'b110?}: begin
                state_d     = ST_DBUSY;
                gnt_d       = GNT_D;
                mem_req_d   = 1'b1;
                mem_we_d    = DWe;
                mem_addr_d  = DAddr;
                mem_wdata_d = DWData;
                st_inc      = IReq;
            end
            {ST_IDLE, 4'b111?},
            {ST_IDLE, 4'b01??}: begin
                state_d    = ST_IBUSY;
                gnt_d      = GNT_I;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = IAddr;
                st_clr     = 1'b1;
            end
            {ST_IBUSY, 4'b???1}: begin
                state_d   = ST_RESP;
                mem_req_d = 1'b0;
                if (!(drop_q || IFlush)) begin
                    fill_d = MemRData;
                end
            end
            {ST_DBUSY, 4'b???1}: begin
                state_d   = ST_RESP;
                mem_req_d = 1'b0;
                if (!mem_we_q) begin
                    drdata_d = MemRData;
                end
            end
            {ST_RESP, 4'b????}: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if ((state_q == ST_IBUSY) && IFlush) begin
            drop_d = 1'b1;
        end
    end

    always_comb begin
        InstrRdy   = (state_q == ST_RESP) && (gnt_q == GNT_I)
                     && !drop_q && !IFlush;
        DataRdy    = (state_q == ST_RESP) && (gnt_q == GNT_D);
        FetchStall = IReq & ~InstrRdy;
        MemStall   = DReq & ~DataRdy;
        MemReq     = mem_req_q;
        MemWe      = mem_we_q;
        MemAddr    = mem_addr_q;
        MemWData   = mem_wdata_q;
        InstrFill  = fill_q;
        DRData     = drdata_q;
    end

`ifndef SYNTHESIS
    a_ireq_held: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_IBUSY) |-> IReq);
    a_dreq_held: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_DBUSY) |-> DReq);
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized scoreboard bench for imem_dmem_arbiter.
// Reference: per-requester expected queues plus a program-order data memory.
module tb_imem_dmem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IReq = 1'b0, IFlush = 1'b0;
    logic [31:0] IAddr = '0;
    logic        InstrRdy;
    logic [31:0] InstrFill;
    logic        DReq = 1'b0, DWe = 1'b0;
    logic [31:0] DAddr = '0, DWData = '0;
    logic        DataRdy;
    logic [31:0] DRData;
    logic        FetchStall, MemStall;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IFlush(IFlush),
        .InstrRdy(InstrRdy), .InstrFill(InstrFill),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DataRdy(DataRdy), .DRData(DRData),
        .FetchStall(FetchStall), .MemStall(MemStall),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData)
    );

    typedef struct {
        logic        we;
        logic [31:0] data;
    } dexp_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_i[$];
    dexp_t       exp_d[$];
    logic [31:0] ref_dmem[logic [31:0]];
    logic [31:0] mem_dmem[logic [31:0]];

    logic hold_ack = 1'b0, stray_ack = 1'b0, in_tx = 1'b0;
    int   dly = 0, min_dly = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h40) return 32'h2402000A;
        return {a[15:0] ^ 16'h2402, ~a[15:0]};
    endfunction

    function automatic logic [31:0] dinit(input logic [31:0] a);
        return a * 32'h9E37 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a < 32'h1000) return instr_of(a);
        if (mem_dmem.exists(a)) return mem_dmem[a];
        return dinit(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory device: random 0..3 cycle ack latency, zero-wait included
    initial begin
        forever begin
            @(posedge clk);
            #1;
            MemAck = 1'b0;
            if (stray_ack) begin
                MemAck   = 1'b1;
                MemRData = 32'hBAD0_BAD0;
            end else if (MemReq && !hold_ack) begin
                if (!in_tx) begin
                    in_tx = 1'b1;
                    dly   = $urandom_range(min_dly, 3);
                end
                if (dly == 0) begin
                    MemAck = 1'b1;
                    in_tx  = 1'b0;
                    if (MemWe) mem_dmem[MemAddr] = MemWData;
                    else       MemRData = mem_read(MemAddr);
                end else begin
                    dly--;
                end
            end else if (!MemReq) begin
                in_tx = 1'b0;
            end
        end
    end

    // Monitor: grants, memory-side stability, responses
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic        p_ireq = 1'b0, p_dreq = 1'b0, p_dwe = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0, p_iaddr = '0, p_daddr = '0, p_dwd = '0;
    logic        win_d, is_d, fill_frozen = 1'b0;
    logic [31:0] last_fill = '0, last_dr = '0;
    int          starve = 0;
    dexp_t       de;
    logic [31:0] ie;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                starve    = 0;
                last_fill = '0;
                last_dr   = '0;
            end else begin
                chk("fetch_stall", 32'(FetchStall), 32'(IReq & ~InstrRdy));
                chk("mem_stall", 32'(MemStall), 32'(DReq & ~DataRdy));
                if (MemReq && !p_req) begin
                    win_d = p_dreq && !(p_ireq && starve == SMAX);
                    is_d  = MemWe || (MemAddr >= 32'h1000);
                    chk("grant_side", 32'(is_d), 32'(win_d));
                    if (!p_ireq && !p_dreq)
                        chk("grant_without_req", 32'(MemReq), 32'd0);
                    if (win_d) begin
                        chk("gnt_daddr", MemAddr, p_daddr);
                        chk("gnt_dwe", 32'(MemWe), 32'(p_dwe));
                        if (p_dwe) chk("gnt_wdata", MemWData, p_dwd);
                        if (p_ireq && starve < SMAX) starve++;
                    end else begin
                        chk("gnt_iaddr", MemAddr, p_iaddr);
                        chk("gnt_iwe", 32'(MemWe), 32'd0);
                        starve = 0;
                    end
                end
                if (MemReq && p_req && !p_ack) begin
                    chk("hold_addr", MemAddr, p_addr);
                    chk("hold_we", 32'(MemWe), 32'(p_we));
                    chk("hold_wdata", MemWData, p_wd);
                end
                if (InstrRdy) begin
                    if (exp_i.size() == 0) begin
                        chk("instr_rdy_unexpected", 32'(InstrRdy), 32'd0);
                    end else begin
                        ie = exp_i.pop_front();
                        chk("instr_fill", InstrFill, instr_of(ie));
                        last_fill   = instr_of(ie);
                        fill_frozen = 1'b0;
                    end
                end else if (fill_frozen) begin
                    chk("fill_hold_after_flush", InstrFill, last_fill);
                end
                if (DataRdy) begin
                    if (exp_d.size() == 0) begin
                        chk("data_rdy_unexpected", 32'(DataRdy), 32'd0);
                    end else begin
                        de = exp_d.pop_front();
                        if (de.we) begin
                            chk("store_drdata_hold", DRData, last_dr);
                        end else begin
                            chk("load_data", DRData, de.data);
                            last_dr = de.data;
                        end
                    end
                end
            end
            p_req   = MemReq;   p_ack  = MemAck;  p_we = MemWe;
            p_addr  = MemAddr;  p_wd   = MemWData;
            p_ireq  = IReq;     p_iaddr = IAddr;
            p_dreq  = DReq;     p_daddr = DAddr;
            p_dwe   = DWe;      p_dwd  = DWData;
        end
    end

    task automatic do_fetch(input logic [31:0] a, input bit flush,
                            input logic [31:0] na);
        bit got = 1'b0;
        bit flushed = 1'b0;
        IReq  = 1'b1;
        IAddr = a;
        exp_i.push_back(a);
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (InstrRdy) begin
                got = 1'b1;
            end else if (flush && !flushed && MemReq && !MemWe
                         && MemAddr == IAddr && !MemAck) begin
                @(posedge clk);
                #1;
                IFlush = 1'b1;
                IAddr  = na;
                void'(exp_i.pop_back());
                exp_i.push_back(na);
                fill_frozen = 1'b1;
                flushed     = 1'b1;
                @(posedge clk);
                #1;
                IFlush = 1'b0;
            end
        end
        if (!got) chk("fetch_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        IReq = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] a,
                           input logic [31:0] wd);
        dexp_t e;
        bit got = 1'b0;
        DReq   = 1'b1;
        DWe    = we;
        DAddr  = a;
        DWData = wd;
        e.we   = we;
        if (we) begin
            e.data      = wd;
            ref_dmem[a] = wd;
        end else begin
            e.data = ref_dmem.exists(a) ? ref_dmem[a] : dinit(a);
        end
        exp_d.push_back(e);
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (DataRdy) got = 1'b1;
        end
        if (!got) chk("data_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        DReq = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    bit got_req;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memwe", 32'(MemWe), 32'd0);
        chk("rst_instrrdy", 32'(InstrRdy), 32'd0);
        chk("rst_datardy", 32'(DataRdy), 32'd0);
        chk("rst_instrfill", InstrFill, 32'd0);
        chk("rst_drdata", DRData, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_fetch(32'h40, 1'b0, 32'h0);
        fork
            do_data(1'b0, 32'h1004, 32'h0);
            do_fetch(32'h44, 1'b0, 32'h0);
        join
        fork
            for (int k = 0; k < 6; k++)
                do_data(1'b1, 32'h1000 + 32'(k * 4), $urandom);
            do_fetch(32'h48, 1'b0, 32'h0);
        join
        min_dly = 3;
        do_fetch(32'h60, 1'b1, 32'h100);
        min_dly = 0;
        do_data(1'b1, 32'h80, 32'hDEADBEEF);

        hold_ack = 1'b1;
        DReq  = 1'b1;
        DWe   = 1'b0;
        DAddr = 32'h1010;
        got_req = 1'b0;
        for (int c = 0; c < 20 && !got_req; c++) begin
            @(negedge clk);
            got_req = MemReq;
        end
        chk("rstop_memreq_seen", 32'(got_req), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        DReq  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstop_memreq_low", 32'(MemReq), 32'd0);
        chk("rstop_datardy_low", 32'(DataRdy), 32'd0);
        hold_ack  = 1'b0;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_quiet", {29'd0, InstrRdy, DataRdy, MemReq}, 32'd0);
        end
        @(posedge clk);
        #1;

        fork
            for (int k = 0; k < 120; k++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                do_fetch(32'($urandom_range(0, 255)) << 2,
                         ($urandom_range(0, 3) == 0),
                         32'($urandom_range(0, 255)) << 2);
            end
            for (int k = 0; k < 120; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                do_data(1'($urandom_range(0, 1)),
                        32'h1000 + (32'($urandom_range(0, 15)) << 2),
                        $urandom);
            end
        join

        repeat (4) @(posedge clk);
        chk("exp_i_drained", 32'(exp_i.size()), 32'd0);
        chk("exp_d_drained", 32'(exp_d.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
